// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state encoding, port indices and counter sizing for
// the two-port memory bus arbiter (fetch vs. data).
package mem_arb_pkg;

    // Arbiter FSM states.
    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccess = 2'd1,
        StAck    = 2'd2
    } arb_state_t;

    // Requester indices; also the encoding held in the grant register.
    localparam logic PORT_FETCH = 1'b0;
    localparam logic PORT_DATA  = 1'b1;

    // Width of the latency down-counter (supports latencies 1..15).
    localparam int unsigned CNT_W = 4;

    // Map a configured read latency onto a legal counter load value.
    function automatic logic [CNT_W-1:0] latency_to_cnt(input int unsigned lat);
        logic [CNT_W-1:0] v;
        if (lat < 1) begin
            v = CNT_W'(1);
        end else if (lat > ((1 << CNT_W) - 1)) begin
            v = {CNT_W{1'b1}};
        end else begin
            v = CNT_W'(lat);
        end
        return v;
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: combinational winner selection between the fetch and data
// requesters. Policy is fixed priority (data wins) by default; defining
// MEM_ARB_ROUND_ROBIN_EN switches contention to alternate against last_grant.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_last_grant,
    output logic o_valid,
    output logic o_winner
);

    // Decide whether anyone is requesting and which port takes the bus.
    always_comb begin
        o_valid  = i_req0 | i_req1;
        o_winner = PORT_FETCH;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        if (i_req0 && i_req1) begin
            // Under contention the port that did not win last time goes next.
            o_winner = ~i_last_grant;
        end else if (i_req1) begin
            o_winner = PORT_DATA;
        end
`else
        if (i_req1) begin
            o_winner = PORT_DATA;
        end
`endif
    end

`ifndef MEM_ARB_ROUND_ROBIN_EN
    // History is irrelevant to fixed priority.
    logic w_unused_last_grant;
    assign w_unused_last_grant = i_last_grant;
`endif

endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares the memory-mapper port between instruction fetch
// (port 0) and data load/store (port 1). One transaction at a time: grant in
// IDLE, hold the address for READ_LATENCY cycles, capture read data, pulse the
// winner's ack for one cycle. Optional macro MEM_ARB_ROUND_ROBIN_EN makes
// contention alternate instead of always favouring the data port.
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic              in_clk,
    input  logic              in_reset,
    input  logic              in_req0,
    input  logic [ADDR_W-1:0] in_addr0,
    input  logic              in_req1,
    input  logic [ADDR_W-1:0] in_addr1,
    input  logic [DATA_W-1:0] in_wdata1,
    input  logic              in_we1,
    input  logic [DATA_W-1:0] in_read_data,
    output logic [ADDR_W-1:0] out_address,
    output logic [DATA_W-1:0] out_data,
    output logic              out_write_en,
    output logic              out_ack0,
    output logic              out_ack1,
    output logic [DATA_W-1:0] out_rdata,
    output logic              out_busy
);

    localparam logic [CNT_W-1:0] CNT_LOAD = latency_to_cnt(READ_LATENCY);

    arb_state_t        r_state;
    arb_state_t        w_state_next;
    logic              r_grant;
    logic              w_grant_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_next;
    logic [DATA_W-1:0] r_rdata;
    logic [DATA_W-1:0] w_rdata_next;

    logic w_last_grant;
    logic w_pick_valid;
    logic w_pick_winner;
    logic w_grant_fire;
    logic w_first_access;

    // A grant happens only when sitting idle with a request pending.
    assign w_grant_fire   = (r_state == StIdle) && w_pick_valid;
    // The counter still holds its load value only in the first ACCESS cycle.
    assign w_first_access = (r_state == StAccess) && (r_cnt == CNT_LOAD);

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic r_last_grant;

    // Remember the most recent winner so contention alternates.
    always_ff @(posedge in_clk) begin
        if (in_reset) begin
            r_last_grant <= PORT_DATA;
        end else if (w_grant_fire) begin
            r_last_grant <= w_pick_winner;
        end
    end

    assign w_last_grant = r_last_grant;
`else
    assign w_last_grant = PORT_DATA;
`endif

    mem_arb_pick u_pick (
        .i_req0       (in_req0),
        .i_req1       (in_req1),
        .i_last_grant (w_last_grant),
        .o_valid      (w_pick_valid),
        .o_winner     (w_pick_winner)
    );

    // State, grant, latency counter and captured read data.
    always_ff @(posedge in_clk) begin
        if (in_reset) begin
            r_state <= StIdle;
            r_grant <= PORT_FETCH;
            r_cnt   <= '0;
            r_rdata <= '0;
        end else begin
            r_state <= w_state_next;
            r_grant <= w_grant_next;
            r_cnt   <= w_cnt_next;
            r_rdata <= w_rdata_next;
        end
    end

    // Next-state: arbitrate in IDLE, count down in ACCESS, single ACK cycle.
    always_comb begin
        w_state_next = r_state;
        w_grant_next = r_grant;
        w_cnt_next   = r_cnt;
        w_rdata_next = r_rdata;
        unique case (r_state)
            StIdle: begin
                if (w_pick_valid) begin
                    w_grant_next = w_pick_winner;
                    w_cnt_next   = CNT_LOAD;
                    w_state_next = StAccess;
                end
            end
            StAccess: begin
                w_cnt_next = r_cnt - CNT_W'(1);
                // Last ACCESS cycle: memory data is valid now, also captured for stores.
                if (r_cnt <= CNT_W'(1)) begin
                    w_rdata_next = in_read_data;
                    w_state_next = StAck;
                end
            end
            StAck: begin
                // No arbitration here, so a still-high request is not re-granted.
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    // Downstream mux and requester acks; everything idles at zero outside ACCESS/ACK.
    always_comb begin
        out_address  = '0;
        out_data     = '0;
        out_write_en = 1'b0;
        out_ack0     = 1'b0;
        out_ack1     = 1'b0;
        unique case (r_state)
            StAccess: begin
                if (r_grant == PORT_DATA) begin
                    out_address  = in_addr1;
                    out_data     = in_wdata1;
                    // Exactly one strobe per store, however long the latency.
                    out_write_en = in_we1 & w_first_access;
                end else begin
                    out_address = in_addr0;
                end
            end
            StAck: begin
                out_ack0 = (r_grant == PORT_FETCH);
                out_ack1 = (r_grant == PORT_DATA);
            end
            default: begin
            end
        endcase
    end

    assign out_rdata = r_rdata;
    assign out_busy  = (r_state != StIdle);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: randomized and directed stimulus for mem_bus_arbiter with
// a transaction-level reference model. The model decides grants from request
// levels and a "bus free from cycle N" time, then predicts the access window,
// write strobe and ack cycle with plain arithmetic; a negedge monitor compares.
module tb_mem_bus_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int          RL = 3;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    localparam bit RR_MODE = 1'b1;
`else
    localparam bit RR_MODE = 1'b0;
`endif

    logic          in_clk = 1'b0;
    logic          in_reset;
    logic          in_req0;
    logic [AW-1:0] in_addr0;
    logic          in_req1;
    logic [AW-1:0] in_addr1;
    logic [DW-1:0] in_wdata1;
    logic          in_we1;
    logic [DW-1:0] in_read_data;
    logic [AW-1:0] out_address;
    logic [DW-1:0] out_data;
    logic          out_write_en;
    logic          out_ack0;
    logic          out_ack1;
    logic [DW-1:0] out_rdata;
    logic          out_busy;

    mem_bus_arbiter #(
        .ADDR_W       (AW),
        .DATA_W       (DW),
        .READ_LATENCY (RL)
    ) dut (
        .in_clk       (in_clk),
        .in_reset     (in_reset),
        .in_req0      (in_req0),
        .in_addr0     (in_addr0),
        .in_req1      (in_req1),
        .in_addr1     (in_addr1),
        .in_wdata1    (in_wdata1),
        .in_we1       (in_we1),
        .in_read_data (in_read_data),
        .out_address  (out_address),
        .out_data     (out_data),
        .out_write_en (out_write_en),
        .out_ack0     (out_ack0),
        .out_ack1     (out_ack1),
        .out_rdata    (out_rdata),
        .out_busy     (out_busy)
    );

    always #5 in_clk = ~in_clk;

    int cyc = 0;
    always @(posedge in_clk) cyc <= cyc + 1;

    // Memory stand-in: value depends on address and cycle, so capture timing matters.
    function automatic logic [31:0] mem_val(input logic [31:0] a, input int c);
        return (a * 32'h9E37_79B1) ^ 32'(c) ^ 32'h5A5A_0000;
    endfunction

    assign in_read_data = mem_val(out_address, cyc);

    typedef struct {
        int          port;
        int          cyc;
        logic [31:0] rdata;
    } exp_ack_t;

    typedef struct {
        int          g;
        bit          port;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          we;
        logic [31:0] rdata;
    } txn_t;

    exp_ack_t exp_q[$];
    txn_t     cur;
    bit       cur_valid = 1'b0;
    logic [31:0] exp_rd = '0;
    bit       last_g = 1'b1;
    int       next_free = 0;
    bit       seen_rst = 1'b0;
    bit       rst_prev = 1'b0;
    bit       ack0_seen = 1'b0;
    bit       ack1_seen = 1'b0;
    int       dir_k = 0;
    bit       dir_prev = 1'b0;
    bit       final_done = 1'b0;
    int       n_checks = 0;
    int       n_fail = 0;

    // Written by the stimulus process only.
    bit dir_on = 1'b0;
    int dir_c0 = 0;
    bit starve_on = 1'b0;
    bit final_req = 1'b0;

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
        end
    endfunction

    // Monitor + reference model, evaluated mid-cycle.
    always @(negedge in_clk) begin
        int       t;
        bit       acc;
        bit       ak;
        bit       win;
        exp_ack_t e;
        t = cyc;
        if (rst_prev) begin
            exp_q.delete();
            cur_valid = 1'b0;
            exp_rd    = '0;
            last_g    = 1'b1;
            next_free = t;
            seen_rst  = 1'b1;
        end
        if (seen_rst) begin
            acc = cur_valid && (t >= cur.g + 1) && (t <= cur.g + RL);
            ak  = cur_valid && (t == cur.g + RL + 1);
            if (ak) exp_rd = cur.rdata;
            chk("address", out_address, acc ? cur.addr : 32'h0);
            chk("wr_data", out_data, (acc && cur.port) ? cur.wdata : 32'h0);
            chk("write_en", out_write_en, acc && cur.port && cur.we && (t == cur.g + 1));
            chk("busy", out_busy, acc || ak);
            chk("rdata_reg", out_rdata, exp_rd);
            chk("single_ack", out_ack0 & out_ack1, 1'b0);
            if (starve_on) chk("starve_ack0", out_ack0, 1'b0);

            if (exp_q.size() > 0 && exp_q[0].cyc < t) begin
                chk("ack_deadline", t, exp_q[0].cyc);
                void'(exp_q.pop_front());
            end
            if (out_ack0 || out_ack1) begin
                chk("ack_pending", exp_q.size() > 0, 1'b1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("ack_port", out_ack1, e.port);
                    chk("ack_cycle", t, e.cyc);
                    chk("ack_rdata", out_rdata, e.rdata);
                end
                if (dir_on) begin
                    if (dir_k < 2) begin
                        chk("contend_port", out_ack1, (dir_k == 0) ? !RR_MODE : RR_MODE);
                        chk("contend_cycle", t, dir_c0 + RL + 1 + dir_k * (RL + 2));
                    end
                    dir_k++;
                end
            end
            if (dir_prev && !dir_on) chk("contend_ack_count", dir_k, 2);
            if (!dir_on) dir_k = 0;

            // Reference arbitration for this cycle.
            if (!in_reset && t >= next_free && (in_req0 || in_req1)) begin
                if (in_req0 && in_req1) win = RR_MODE ? !last_g : 1'b1;
                else win = in_req1;
                last_g    = win;
                cur.g     = t;
                cur.port  = win;
                cur.addr  = win ? in_addr1 : in_addr0;
                cur.wdata = in_wdata1;
                cur.we    = in_we1;
                cur.rdata = mem_val(cur.addr, t + RL);
                cur_valid = 1'b1;
                e.port    = int'(win);
                e.cyc     = t + RL + 1;
                e.rdata   = cur.rdata;
                exp_q.push_back(e);
                next_free = t + RL + 2;
            end
            if (final_req && !final_done) begin
                chk("queue_drained", exp_q.size(), 0);
                chk("final_idle", out_busy, 1'b0);
                final_done = 1'b1;
            end
        end
        dir_prev  = dir_on;
        ack0_seen = out_ack0;
        ack1_seen = out_ack1;
        rst_prev  = in_reset;
    end

    task automatic new0();
        in_req0  = 1'b1;
        in_addr0 = $urandom;
    endtask

    task automatic new1();
        in_req1   = 1'b1;
        in_addr1  = $urandom;
        in_wdata1 = $urandom;
        in_we1    = 1'($urandom_range(1));
    endtask

    // One clock of requester behaviour: hold until ack, then drop or re-issue.
    task automatic step(input int r0, input int r1, input bit k0, input bit k1);
        @(posedge in_clk);
        #1;
        if (in_req0) begin
            if (ack0_seen) begin
                in_req0 = 1'b0;
                if (k0) new0();
            end
        end else if (int'($urandom_range(99)) < r0) begin
            new0();
        end
        if (in_req1) begin
            if (ack1_seen) begin
                in_req1 = 1'b0;
                if (k1) new1();
            end
        end else if (int'($urandom_range(99)) < r1) begin
            new1();
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 60; i++) begin
            if (!in_req0 && !in_req1 && !out_busy) break;
            step(0, 0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        in_reset  = 1'b1;
        in_req0   = 1'b0;
        in_addr0  = '0;
        in_req1   = 1'b0;
        in_addr1  = '0;
        in_wdata1 = '0;
        in_we1    = 1'b0;
        repeat (3) @(posedge in_clk);
        #1 in_reset = 1'b0;
        repeat (2) step(0, 0, 1'b0, 1'b0);

        // Contention right after reset: both requests raised together.
        @(posedge in_clk);
        #1;
        in_req0   = 1'b1;
        in_addr0  = 32'h0000_0100;
        in_req1   = 1'b1;
        in_addr1  = 32'h0000_0200;
        in_we1    = 1'b0;
        in_wdata1 = 32'hCAFE_0001;
        dir_c0    = cyc;
        dir_on    = 1'b1;
        repeat (2 * RL + 8) step(0, 0, 1'b0, 1'b0);
        dir_on = 1'b0;
        drain();

        // Single fetch.
        @(posedge in_clk);
        #1;
        in_req0  = 1'b1;
        in_addr0 = 32'h0000_0010;
        repeat (RL + 4) step(0, 0, 1'b0, 1'b0);
        drain();

        // Single store.
        @(posedge in_clk);
        #1;
        in_req1   = 1'b1;
        in_addr1  = 32'h0038_0400;
        in_wdata1 = 32'h1234_5678;
        in_we1    = 1'b1;
        repeat (RL + 4) step(0, 0, 1'b0, 1'b0);
        drain();

        // Load interrupted by reset while in ACCESS: no ack may follow.
        @(posedge in_clk);
        #1;
        in_req1  = 1'b1;
        in_addr1 = 32'h0000_0040;
        in_we1   = 1'b0;
        repeat (2) step(0, 0, 1'b0, 1'b0);
        in_reset = 1'b1;
        in_req1  = 1'b0;
        @(posedge in_clk);
        #1 in_reset = 1'b0;
        repeat (8) step(0, 0, 1'b0, 1'b0);

        // Randomized traffic, with one reset pulse in the middle.
        for (int blk = 0; blk < 12; blk++) begin
            int r0;
            int r1;
            bit k0;
            bit k1;
            r0 = int'($urandom_range(90));
            r1 = int'($urandom_range(90));
            k0 = 1'($urandom_range(1));
            k1 = 1'($urandom_range(1));
            repeat (100) step(r0, r1, k0, k1);
            if (blk == 5) begin
                in_reset = 1'b1;
                step(r0, r1, k0, k1);
                in_reset = 1'b0;
            end
        end
        drain();

        // Port 1 keeps re-requesting while port 0 waits.
        starve_on = !RR_MODE;
        @(posedge in_clk);
        #1;
        new0();
        new1();
        repeat (60) step(0, 0, 1'b0, 1'b1);
        starve_on = 1'b0;
        drain();

        repeat (3) step(0, 0, 1'b0, 1'b0);
        final_req = 1'b1;
        for (int i = 0; i < 10 && !final_done; i++) @(posedge in_clk);
        if (!final_done) begin
            $display("FAIL final_check: monitor did not complete, got 0 expected 1");
            $fatal(1);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
